// File: rtl/matrix_scan_pkg.sv
// Shared playfield constants and scan-state encoding for the LED matrix driver.
// Also holds the row-major bit-index convention used by the game core.
package matrix_scan_pkg;

    localparam int ROW_DEF = 10;
    localparam int COL_DEF = 8;

    typedef enum logic [1:0] {
        S_LOAD  = 2'd0,
        S_BLANK = 2'd1,
        S_DRIVE = 2'd2
    } scan_state_e;

    // Playfield bit for row r (0 = top), column c (0 = left).
    function automatic int bit_idx(input int r, input int c, input int ncol);
        return r * ncol + c;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scan_timer.sv
// Slot counter and row index for the matrix scan, with terminal-count flags.
// The row index wraps explicitly so non-power-of-two row counts stay in range.
module scan_timer
    import matrix_scan_pkg::*;
#(
    parameter int ROW   = ROW_DEF,
    parameter int DIV   = 50000,
    parameter int BLANK = 4,
    localparam int ROW_W = cw(ROW),
    localparam int CNT_W = cw(DIV)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [ROW_W-1:0] row,
    output logic             blank_done,
    output logic             slot_done,
    output logic             last_row
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [ROW_W-1:0] row_q, row_d;

    assign blank_done = (cnt_q == CNT_W'(BLANK - 1));
    assign slot_done  = (cnt_q == CNT_W'(DIV - 1));
    assign last_row   = (row_q == ROW_W'(ROW - 1));
    assign row        = row_q;

    // Next count: clear on frame load, else step through the slot and rows.
    always_comb begin
        cnt_d = cnt_q;
        row_d = row_q;
        if (clr) begin
            cnt_d = '0;
            row_d = '0;
        end else if (en) begin
            if (slot_done) begin
                cnt_d = '0;
                row_d = last_row ? '0 : row_q + 1'b1;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Counter registers, asynchronously cleared.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            cnt_q <= '0;
            row_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            row_q <= row_d;
        end
    end

endmodule

// File: rtl/matrix_scan.sv
// Time-multiplexed LED dot-matrix driver with tear-free frame snapshots.
// Blanks between rows and flashes the whole field while game_over is high.
module matrix_scan
    import matrix_scan_pkg::*;
#(
    parameter int ROW          = ROW_DEF,
    parameter int COL          = COL_DEF,
    parameter int DIV          = 50000,
    parameter int BLANK        = 4,
    parameter int BLINK_FRAMES = 25
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ROW*COL-1:0] Background1,
    input  logic               game_over,
    output logic [ROW-1:0]     row_sel,
    output logic [COL-1:0]     col_data,
    output logic               frame_start
);

    localparam int ROW_W = cw(ROW);
    localparam int FC_W  = cw(BLINK_FRAMES);

    scan_state_e        state_q, state_d;
    logic [ROW*COL-1:0] frame_buf_q, frame_buf_d;
    logic [FC_W-1:0]    fcnt_q, fcnt_d;
    logic               blink_off_q, blink_off_d;
    logic [ROW-1:0]     row_sel_q, row_sel_d;
    logic [COL-1:0]     col_data_q, col_data_d;
    logic               frame_start_q, frame_start_d;

    logic               tmr_clr;
    logic               tmr_en;
    logic [ROW_W-1:0]   row_i;
    logic               blank_done;
    logic               slot_done;
    logic               last_row;

    scan_timer #(
        .ROW   (ROW),
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr        (tmr_clr),
        .en         (tmr_en),
        .row        (row_i),
        .blank_done (blank_done),
        .slot_done  (slot_done),
        .last_row   (last_row)
    );

    assign row_sel     = row_sel_q;
    assign col_data    = col_data_q;
    assign frame_start = frame_start_q;

    // Scan sequencing, snapshot/blink update and output decode for this cycle.
    always_comb begin
        state_d       = state_q;
        frame_buf_d   = frame_buf_q;
        fcnt_d        = fcnt_q;
        blink_off_d   = blink_off_q;
        row_sel_d     = '1;
        col_data_d    = '0;
        frame_start_d = 1'b0;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;
        case (state_q)
            S_LOAD: begin
                frame_buf_d   = Background1;
                frame_start_d = 1'b1;
                tmr_clr       = 1'b1;
                if (!game_over) begin
                    fcnt_d      = '0;
                    blink_off_d = 1'b0;
                end else if (fcnt_q == FC_W'(BLINK_FRAMES - 1)) begin
                    fcnt_d      = '0;
                    blink_off_d = ~blink_off_q;
                end else begin
                    fcnt_d = fcnt_q + 1'b1;
                end
                state_d = S_BLANK;
            end
            S_BLANK: begin
                tmr_en = 1'b1;
                if (blank_done) begin
                    state_d = S_DRIVE;
                end
            end
            S_DRIVE: begin
                tmr_en = 1'b1;
                for (int i = 0; i < ROW; i++) begin
                    if (row_i == ROW_W'(i)) begin
                        row_sel_d[i] = 1'b0;
                    end
                end
                if (!blink_off_q) begin
                    col_data_d = frame_buf_q[bit_idx(int'(row_i), 0, COL) +: COL];
                end
                if (slot_done) begin
                    state_d = last_row ? S_LOAD : S_BLANK;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State, frame buffer, blink and registered outputs; reset blanks the matrix.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q       <= S_LOAD;
            frame_buf_q   <= '0;
            fcnt_q        <= '0;
            blink_off_q   <= 1'b0;
            row_sel_q     <= '1;
            col_data_q    <= '0;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            frame_buf_q   <= frame_buf_d;
            fcnt_q        <= fcnt_d;
            blink_off_q   <= blink_off_d;
            row_sel_q     <= row_sel_d;
            col_data_q    <= col_data_d;
            frame_start_q <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan with DIV=8, BLANK=2, ROW=10, COL=8, BLINK_FRAMES=2.
// Frame cycle 1 is the cycle frame_start is high; row r is lit on cycles 4+8r..9+8r.
module tb_matrix_scan;

    localparam int ROW = 10;
    localparam int COL = 8;

    typedef struct {
        int             cyc;
        logic [ROW-1:0] rs;
        logic [COL-1:0] cd;
        logic           fs;
    } vec_t;

    logic               clk;
    logic               rst_n;
    logic [ROW*COL-1:0] bg;
    logic               go;
    logic [ROW-1:0]     row_sel;
    logic [COL-1:0]     col_data;
    logic               frame_start;

    int n_cmp = 0;
    int n_err = 0;
    int fc = 0;
    int abs_cyc = 0;
    int prev_fs = -1;

    matrix_scan #(
        .ROW          (ROW),
        .COL          (COL),
        .DIV          (8),
        .BLANK        (2),
        .BLINK_FRAMES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Background1 (bg),
        .game_over   (go),
        .row_sel     (row_sel),
        .col_data    (col_data),
        .frame_start (frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (frame cycle %0d)",
                     name, act, exp, fc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        fc++;
        abs_cyc++;
        if (!rst_n) begin
            chk("one_row_max", ($countones(~row_sel) <= 1) ? 1 : 0, 1);
            if (frame_start) begin
                if (prev_fs >= 0) begin
                    chk("frame_period", abs_cyc - prev_fs, 81);
                end
                prev_fs = abs_cyc;
            end
        end
    endtask

    task automatic goto(input int c);
        while (fc < c) tick();
    endtask

    task automatic wait_fs(input int bound);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!frame_start && n < bound);
        chk("frame_start_seen", frame_start, 1);
        fc = 1;
    endtask

    task automatic chk_row(input string name, input int r,
                           input logic [COL-1:0] exp_cd);
        logic [ROW-1:0] exp_rs;
        exp_rs = '1;
        exp_rs[r] = 1'b0;
        goto(4 + 8 * r);
        chk({name, "_rs"}, row_sel, exp_rs);
        chk({name, "_cd"}, col_data, exp_cd);
    endtask

    vec_t tv [16];
    logic [COL-1:0] blink_exp [5];

    initial begin
        tv[0]  = '{1,  10'h3FF, 8'h00, 1'b1};
        tv[1]  = '{2,  10'h3FF, 8'h00, 1'b0};
        tv[2]  = '{3,  10'h3FF, 8'h00, 1'b0};
        tv[3]  = '{4,  10'h3FE, 8'hFF, 1'b0};
        tv[4]  = '{6,  10'h3FE, 8'hFF, 1'b0};
        tv[5]  = '{9,  10'h3FE, 8'hFF, 1'b0};
        tv[6]  = '{10, 10'h3FF, 8'h00, 1'b0};
        tv[7]  = '{11, 10'h3FF, 8'h00, 1'b0};
        tv[8]  = '{12, 10'h3FD, 8'hFF, 1'b0};
        tv[9]  = '{17, 10'h3FD, 8'hFF, 1'b0};
        tv[10] = '{74, 10'h3FF, 8'h00, 1'b0};
        tv[11] = '{75, 10'h3FF, 8'h00, 1'b0};
        tv[12] = '{76, 10'h1FF, 8'hFF, 1'b0};
        tv[13] = '{81, 10'h1FF, 8'hFF, 1'b0};
        tv[14] = '{82, 10'h3FF, 8'h00, 1'b1};
        tv[15] = '{85, 10'h3FE, 8'hFF, 1'b0};
        blink_exp = '{8'hFF, 8'h00, 8'h00, 8'hFF, 8'hFF};

        rst_n = 1'b1;
        bg    = '1;
        go    = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_row_sel", row_sel, 10'h3FF);
        chk("rst_col_data", col_data, 8'h00);
        chk("rst_frame_start", frame_start, 1'b0);

        rst_n = 1'b0;
        fc = 0;
        for (int i = 0; i < 16; i++) begin
            goto(tv[i].cyc);
            chk($sformatf("v%0d_rs", tv[i].cyc), row_sel, tv[i].rs);
            chk($sformatf("v%0d_cd", tv[i].cyc), col_data, tv[i].cd);
            chk($sformatf("v%0d_fs", tv[i].cyc), frame_start, tv[i].fs);
        end

        for (int r = 0; r < ROW; r++) begin
            bg[r*COL +: COL] = (r % 2 == 0) ? 8'h55 : 8'hAA;
        end
        wait_fs(100);
        for (int r = 0; r < ROW; r++) begin
            chk_row($sformatf("chk_r%0d", r), r, (r % 2 == 0) ? 8'h55 : 8'hAA);
        end

        bg = '0;
        wait_fs(100);
        goto(34);
        bg = '1;
        for (int r = 4; r < ROW; r++) begin
            chk_row($sformatf("tear_r%0d", r), r, 8'h00);
        end
        wait_fs(100);
        chk_row("new_r0", 0, 8'hFF);
        chk_row("new_r1", 1, 8'hFF);

        go = 1'b1;
        for (int f = 0; f < 5; f++) begin
            wait_fs(100);
            chk_row($sformatf("blink_f%0d_r0", f + 1), 0, blink_exp[f]);
            chk_row($sformatf("blink_f%0d_r5", f + 1), 5, blink_exp[f]);
        end
        wait_fs(100);
        chk_row("blink_f6_r0", 0, 8'h00);
        goto(20);
        go = 1'b0;
        chk_row("drop_f6_r5", 5, 8'h00);
        wait_fs(100);
        chk_row("drop_f7_r0", 0, 8'hFF);

        goto(5);
        #1 rst_n = 1'b1;
        #1;
        chk("async_rst_rs", row_sel, 10'h3FF);
        chk("async_rst_cd", col_data, 8'h00);
        chk("async_rst_fs", frame_start, 1'b0);
        repeat (3) tick();
        chk("held_rst_rs", row_sel, 10'h3FF);
        rst_n = 1'b0;
        prev_fs = -1;
        fc = 0;
        goto(1);
        chk("rel_fs_c1", frame_start, 1'b1);
        goto(2);
        chk("rel_fs_c2", frame_start, 1'b0);
        goto(3);
        chk("rel_rs_c3", row_sel, 10'h3FF);
        goto(4);
        chk("rel_rs_c4", row_sel, 10'h3FE);
        chk("rel_cd_c4", col_data, 8'hFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/matrix_scan.md
# matrix_scan

Time-multiplexed LED dot-matrix driver that sits directly downstream of the game core. Takes the flattened ROW×COL playfield bitmap `Background1` plus the `game_over` flag and drives one matrix row at a time with blanking between rows. Latches a frame snapshot only at frame boundaries, so a mid-frame playfield update never tears the display. Flashes the whole field while `game_over` is high.

## Interface
- `ROW`, 10, number of matrix rows (playfield height).
- `COL`, 8, number of matrix columns (playfield width).
- `DIV`, 50000, clocks per row slot; legal range BLANK+1 .. 2^20-1.
- `BLANK`, 4, leading clocks of each slot with all rows off (ghosting guard); ≥1.
- `BLINK_FRAMES`, 25, frames per blink half-period during game over; ≥1.

Ports:
- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: asynchronous, active-high reset. Asserted when 1; the name is retained.
- `Background1` input ROW*COL: playfield. Bit `r*COL+c` is row r (0 = top), column c (0 = left); 1 = lit.
- `game_over` input 1: level. Enables blink.
- `row_sel` output ROW: active-low row enable. At most one bit is 0.
- `col_data` output COL: active-high column drive for the selected row.
- `frame_start` output 1: one-cycle pulse when a new frame snapshot loads.

## Operation
- Registers:
  - `frame_buf` [ROW*COL-1:0]
  - slot counter `cnt` (clog2(DIV) bits)
  - row index `row` (clog2(ROW) bits)
  - state
  - frame counter `fcnt` (clog2(BLINK_FRAMES) bits)
  - `blink_off` flag
- States:
  - LOAD: one cycle.
    - `frame_buf` <= `Background1`.
    - `frame_start` = 1.
    - `row` <= 0, `cnt` <= 0.
    - Advance blink logic. → BLANK.
  - BLANK: `row_sel` all 1, `col_data` 0.
    - `cnt` counts 0..BLANK-1; at BLANK-1 → DRIVE.
  - DRIVE:
    - `row_sel[row]` = 0.
    - `col_data` = `frame_buf[row*COL +: COL]`, forced to 0 when `blink_off`.
    - `cnt` continues to DIV-1.
    - At DIV-1: `cnt` <= 0. If `row` == ROW-1 → LOAD, else `row` <= row+1 → BLANK.
- Blink, evaluated in LOAD:
  - If `game_over` = 0: `fcnt` <= 0, `blink_off` <= 0.
  - Otherwise `fcnt` increments. On reaching BLINK_FRAMES-1, `fcnt` wraps to 0 and `blink_off` toggles.
- `game_over` falling mid-frame clears `blink_off` only at the next LOAD; the current frame finishes unchanged.
- `Background1` changes mid-frame are ignored until the next LOAD.
- `row` never exceeds ROW-1; non-power-of-two ROW wraps explicitly, not by overflow.
- Outputs are registered, decoded from the next-state values, so there is no combinational path from `Background1` or `game_over` to any output.

## Timing
- Reset values:
  - state = LOAD, `row` = 0, `cnt` = 0, `fcnt` = 0, `blink_off` = 0, `frame_buf` = 0.
  - `row_sel` = all 1, `col_data` = 0, `frame_start` = 0.
- The first clock after reset release executes LOAD: `frame_start` is high during that cycle.
- Frame period is exactly 1 + ROW*DIV clocks. For each row:
  - BLANK clocks dark.
  - DIV-BLANK clocks lit.
- Frame snapshot latency: `Background1` sampled in LOAD appears on `col_data` BLANK+1 cycles later for row 0.
- Row change: the previous row's `row_sel` bit deasserts in the same cycle BLANK begins. No cycle ever has two rows enabled.
- Reset asserted mid-slot: outputs go to reset values immediately (asynchronously). The scan restarts at LOAD.

## Structure
- Shared package, with the playfield constants used by the game core:
  - ROW and COL defaults.
  - The bit-index convention `r*COL+c`.
  - The scan state encoding (LOAD, BLANK, DRIVE).
- One natural sub-module: `scan_timer` (`cnt`/`row` counters with terminal-count flags).
- The state machine, frame buffer and blink logic stay in `matrix_scan`.

## Test plan
Bench parameters: DIV=8, BLANK=2, ROW=10, COL=8, BLINK_FRAMES=2.
- Reset release with `Background1` = all 1:
  - `frame_start` pulses on cycle 1.
  - Cycles 2–3: `row_sel` = 10'h3FF.
  - Cycles 4–9: `row_sel` = 10'h3FE and `col_data` = 8'hFF.
  - Frame period is 81 clocks.
- Checkerboard `Background1`: each row r shows `col_data` = 8'h55 for even r and 8'hAA for odd r. Every cycle has at most one 0 in `row_sel`.
- Change `Background1` from 0 to all 1 during row 4 of a frame: the rest of that frame shows 0. The next frame shows 8'hFF from row 0.
- `game_over` = 1 with full field: frames alternate in pairs, 2 lit and 2 dark. `blink_off` toggles at every second LOAD. Dropping `game_over` mid-frame restores lighting at the next LOAD.
- Assert `rst_n` mid-DRIVE for 3 cycles:
  - `row_sel` = 10'h3FF and `col_data` = 0 within the same cycle.
  - After release, LOAD occurs and row 0 is driven after BLANK.
